// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Sequences the registered 6502 ALU for the CPU core. One instruction-level
//   request is accepted per valid/ready handshake, decoded into ALU operand,
//   select and carry-in lines, held for the ALU pipeline latency, and the
//   result is returned with N/Z/C/V flags plus an update mask through a
//   second valid/ready handshake.
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     req_valid/req_ready      request handshake
//     req_op/a/b/cin/dec       instruction op code, operands, P.C, P.D
//     alu_a, alu_b, alu_cin    ALU operands and carry-in
//     alu_sums..alu_bcds       ALU function selects (one-hot, BCDS with SUMS)
//     alu_result/of/cout/hcout ALU registered outputs (hcout reserved)
//     rsp_valid/rsp_ready      response handshake
//     rsp_result/flags/mask    result byte, {N,Z,C,V}, {N,Z,C,V} update enables
module alu_sequencer #(
  parameter int ALU_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic       req_cin,
  input  logic       req_dec,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_sums,
  output logic       alu_ands,
  output logic       alu_ors,
  output logic       alu_xors,
  output logic       alu_srs,
  output logic       alu_bcds,
  output logic       alu_cin,
  input  logic [7:0] alu_result,
  input  logic       alu_of,
  input  logic       alu_cout,
  input  logic       alu_hcout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic [3:0] rsp_flags,
  output logic [3:0] rsp_mask
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAT = 4'(ALU_LATENCY);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [7:0] alu_a_reg, alu_a_next;
  logic [7:0] alu_b_reg, alu_b_next;
  logic [5:0] sel_reg, sel_next;       // {sums, ands, ors, xors, srs, bcds}
  logic       alu_cin_reg, alu_cin_next;
  logic [3:0] mask_reg, mask_next;     // mask of the op in flight
  logic [7:0] rsp_result_reg, rsp_result_next;
  logic [3:0] rsp_flags_reg, rsp_flags_next;
  logic [3:0] rsp_mask_reg, rsp_mask_next;

  logic [5:0] dec_sel;
  logic [7:0] dec_b;
  logic       dec_cin;
  logic [3:0] dec_mask;

  // Carry-half output of the ALU is reserved for future use.
  logic unused_hcout;
  assign unused_hcout = alu_hcout;

  // Instruction decode. Operands not used by a function (B for shifts,
  // carry-in for logic ops) are tied to 0 so the ALU inputs stay quiet.
  always_comb begin
    dec_sel  = 6'b000000;
    dec_b    = req_b;
    dec_cin  = 1'b0;
    dec_mask = 4'b0000;
    case (req_op)
      4'd0: begin  // ADC
        dec_sel = {5'b10000, req_dec}; dec_cin = req_cin; dec_mask = 4'b1111;
      end
      4'd1: begin  // SBC: A + ~B + C
        dec_sel = {5'b10000, req_dec}; dec_b = ~req_b; dec_cin = req_cin;
        dec_mask = 4'b1111;
      end
      4'd2: begin dec_sel = 6'b010000; dec_mask = 4'b1100; end  // AND
      4'd3: begin dec_sel = 6'b001000; dec_mask = 4'b1100; end  // ORA
      4'd4: begin dec_sel = 6'b000100; dec_mask = 4'b1100; end  // EOR
      4'd5: begin  // LSR: zero shifted into bit 7
        dec_sel = 6'b000010; dec_b = 8'h00; dec_mask = 4'b1110;
      end
      4'd6: begin  // ROR: carry shifted into bit 7
        dec_sel = 6'b000010; dec_b = 8'h00; dec_cin = req_cin; dec_mask = 4'b1110;
      end
      4'd7: begin  // ASL as A + A
        dec_sel = 6'b100000; dec_b = req_a; dec_mask = 4'b1110;
      end
      4'd8: begin  // ROL as A + A + C
        dec_sel = 6'b100000; dec_b = req_a; dec_cin = req_cin; dec_mask = 4'b1110;
      end
      4'd9: begin  // INC as A + 0 + 1
        dec_sel = 6'b100000; dec_b = 8'h00; dec_cin = 1'b1; dec_mask = 4'b1100;
      end
      4'd10: begin  // DEC as A + FF + 0
        dec_sel = 6'b100000; dec_b = 8'hFF; dec_mask = 4'b1100;
      end
      4'd11: begin  // CMP: binary subtract, no carry dependency
        dec_sel = 6'b100000; dec_b = ~req_b; dec_cin = 1'b1; dec_mask = 4'b1110;
      end
      default: begin  // illegal: pass A through an OR with zero, touch no flags
        dec_sel = 6'b001000; dec_b = 8'h00; dec_mask = 4'b0000;
      end
    endcase
  end

  // Next-state and datapath updates.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    alu_a_next      = alu_a_reg;
    alu_b_next      = alu_b_reg;
    sel_next        = sel_reg;
    alu_cin_next    = alu_cin_reg;
    mask_next       = mask_reg;
    rsp_result_next = rsp_result_reg;
    rsp_flags_next  = rsp_flags_reg;
    rsp_mask_next   = rsp_mask_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next   = EXEC;
          cnt_next     = LAT;
          alu_a_next   = req_a;
          alu_b_next   = dec_b;
          sel_next     = dec_sel;
          alu_cin_next = dec_cin;
          mask_next    = dec_mask;
        end
      end
      EXEC: begin
        if (cnt_reg == 4'd0) begin
          state_next      = RESP;
          rsp_result_next = alu_result;
          rsp_flags_next  = {alu_result[7], alu_result == 8'h00, alu_cout, alu_of}
                            & mask_reg;
          rsp_mask_next   = mask_reg;
          alu_a_next      = 8'h00;
          alu_b_next      = 8'h00;
          sel_next        = 6'b000000;
          alu_cin_next    = 1'b0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_result_next = 8'h00;
          rsp_flags_next  = 4'b0000;
          rsp_mask_next   = 4'b0000;
          if (req_valid) begin
            // Response retires and the next request enters on the same edge.
            state_next   = EXEC;
            cnt_next     = LAT;
            alu_a_next   = req_a;
            alu_b_next   = dec_b;
            sel_next     = dec_sel;
            alu_cin_next = dec_cin;
            mask_next    = dec_mask;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      alu_a_reg      <= 8'h00;
      alu_b_reg      <= 8'h00;
      sel_reg        <= 6'b000000;
      alu_cin_reg    <= 1'b0;
      mask_reg       <= 4'b0000;
      rsp_result_reg <= 8'h00;
      rsp_flags_reg  <= 4'b0000;
      rsp_mask_reg   <= 4'b0000;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      alu_a_reg      <= alu_a_next;
      alu_b_reg      <= alu_b_next;
      sel_reg        <= sel_next;
      alu_cin_reg    <= alu_cin_next;
      mask_reg       <= mask_next;
      rsp_result_reg <= rsp_result_next;
      rsp_flags_reg  <= rsp_flags_next;
      rsp_mask_reg   <= rsp_mask_next;
    end
  end

  assign req_ready  = !rst && ((state_reg == IDLE) || ((state_reg == RESP) && rsp_ready));
  assign rsp_valid  = (state_reg == RESP);
  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign alu_sums   = sel_reg[5];
  assign alu_ands   = sel_reg[4];
  assign alu_ors    = sel_reg[3];
  assign alu_xors   = sel_reg[2];
  assign alu_srs    = sel_reg[1];
  assign alu_bcds   = sel_reg[0];
  assign alu_cin    = alu_cin_reg;
  assign rsp_result = rsp_result_reg;
  assign rsp_flags  = rsp_flags_reg;
  assign rsp_mask   = rsp_mask_reg;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Controller that sequences the registered 6502 ALU (input register stage plus output register stage) on behalf of the CPU core. Accepts one instruction-level ALU request through a valid/ready handshake and decodes it into ALU select lines, operand muxing and carry-in. It waits out the ALU pipeline latency, then returns the result with N/Z/C/V flags and a flag-update mask through a second valid/ready handshake. Sits between the instruction decoder/execute FSM and the ALU instance.

Parameters:
ALU_LATENCY, 2, cycles from ALU operand inputs stable to alu_result valid (legal 1..15)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept request
req_op  input  4  0 ADC,1 SBC,2 AND,3 ORA,4 EOR,5 LSR,6 ROR,7 ASL,8 ROL,9 INC,10 DEC,11 CMP,12-15 illegal
req_a  input  8  operand A (accumulator/memory)
req_b  input  8  operand B
req_cin  input  1  current P.C
req_dec  input  1  current P.D
alu_a  output  8  ALU operand A
alu_b  output  8  ALU operand B
alu_sums, alu_ands, alu_ors, alu_xors, alu_srs, alu_bcds  output  1 each  ALU function selects (one-hot, BCDS only alongside SUMS)
alu_cin  output  1  ALU carry-in
alu_result  input  8  ALU registered result
alu_of, alu_cout, alu_hcout  input  1 each  ALU overflow, carry-out, half-carry (hcout unused, reserved)
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  8  result byte
rsp_flags  output  4  {N,Z,C,V}
rsp_mask  output  4  {N,Z,C,V} update enables

Behaviour:
- Reset (rst high at clk edge): state IDLE, counter 0; all alu_* outputs, rsp_* outputs 0. req_ready 0 while rst high.
- States: IDLE, EXEC, RESP. req_ready = (IDLE) or (RESP and rsp_ready).
- Accept on edge with req_valid & req_ready: decoded alu_* outputs registered at that edge, counter := ALU_LATENCY, state EXEC.
- EXEC: alu_* held stable; counter decrements each edge; at edge with counter==0, capture result/flags into rsp regs, selects cleared to 0, state RESP. rsp_valid therefore rises ALU_LATENCY+1 edges after accept edge (3 at default).
- RESP: rsp_valid=1, rsp_* held stable until rsp_ready. Handshake edge: if req_valid also high, new request accepted same edge (goes EXEC), else IDLE. Throughput: one op per ALU_LATENCY+2 cycles.
- Decode (alu_a=req_a unless noted):
  ADC: SUMS, b=req_b, cin=req_cin, bcds=req_dec, mask 1111.
  SBC: SUMS, b=~req_b, cin=req_cin, bcds=req_dec, mask 1111.
  CMP: SUMS, b=~req_b, cin=1, bcds=0, mask 1110.
  AND/ORA/EOR: ANDS/ORS/XORS, b=req_b, mask 1100.
  LSR: SRS, cin=0; ROR: SRS, cin=req_cin; mask 1110 (ALU contract: cin->bit7, cout=A[0]).
  ASL: SUMS, b=req_a, cin=0; ROL: same, cin=req_cin; mask 1110.
  INC: SUMS, b=0x00, cin=1; DEC: SUMS, b=0xFF, cin=0; mask 1100.
  Illegal: ORS, b=0x00, cin=0; mask 0000; result = req_a.
- Flags: N=result[7]; Z=(result==0); C=alu_cout; V=alu_of. Flags outside mask driven 0.
- Operand/select outputs are 0 in IDLE and RESP.
- rst mid-EXEC or mid-RESP: operation discarded, no response; IDLE next cycle.
- req_* sampled only on accept edge; changes at other times ignored.

Test Plan:
- ADC a=0x50 b=0x50 cin=0 dec=0 -> alu_sums=1, alu_cin=0; rsp_valid exactly 3 cycles after accept; result 0xA0, flags N1 Z0 C0 V1, mask 1111.
- SBC a=0x00 b=0x01 cin=1 -> alu_b=0xFE, alu_cin=1; result 0xFF, flags N1 Z0 C0 V0.
- CMP a=0x40 b=0x40 -> alu_cin=1, alu_bcds=0; result 0x00, flags N0 Z1 C1 V0, mask 1110.
- ROR a=0x01 cin=1 -> alu_srs=1, alu_cin=1; result 0x80, flags N1 Z0 C1, mask 1110; op 13 a=0x5A -> result 0x5A, mask 0000.
- Backpressure: rsp_ready low 5 cycles -> rsp_* stable; rsp_ready and req_valid (INC a=0xFF) same cycle -> accepted same edge, result 0x00 Z1 mask 1100.
- Assert rst one cycle during EXEC -> no rsp_valid, all outputs 0 next cycle, req_ready 1 after rst drops.
